// File: rtl/pep_ldg_axi_rd_arb.sv
// Shares one AXI4 read master between REQ_NB load-GLWE requesters: round-robin AR grant,
// an order FIFO of granted requester indices routes in-order R beats back to their owner.
module pep_ldg_axi_rd_arb #(
   parameter int REQ_NB       = 2,
   parameter int OUTSTD_DEPTH = 8,
   parameter int AXI4_ID_W    = 4,
   parameter int AXI4_ADD_W   = 32,
   parameter int AXI4_DATA_W  = 64
) (
   input  logic                                   clk,
   input  logic                                   s_rst,
   input  logic [REQ_NB-1:0][AXI4_ID_W-1:0]       s_axi4_arid,
   input  logic [REQ_NB-1:0][AXI4_ADD_W-1:0]      s_axi4_araddr,
   input  logic [REQ_NB-1:0][7:0]                 s_axi4_arlen,
   input  logic [REQ_NB-1:0][2:0]                 s_axi4_arsize,
   input  logic [REQ_NB-1:0][1:0]                 s_axi4_arburst,
   input  logic [REQ_NB-1:0]                      s_axi4_arvalid,
   output logic [REQ_NB-1:0]                      s_axi4_arready,
   output logic [REQ_NB-1:0][AXI4_ID_W-1:0]       s_axi4_rid,
   output logic [REQ_NB-1:0][AXI4_DATA_W-1:0]     s_axi4_rdata,
   output logic [REQ_NB-1:0][1:0]                 s_axi4_rresp,
   output logic [REQ_NB-1:0]                      s_axi4_rlast,
   output logic [REQ_NB-1:0]                      s_axi4_rvalid,
   input  logic [REQ_NB-1:0]                      s_axi4_rready,
   output logic [AXI4_ID_W-1:0]                   m_axi4_arid,
   output logic [AXI4_ADD_W-1:0]                  m_axi4_araddr,
   output logic [7:0]                             m_axi4_arlen,
   output logic [2:0]                             m_axi4_arsize,
   output logic [1:0]                             m_axi4_arburst,
   output logic                                   m_axi4_arvalid,
   input  logic                                   m_axi4_arready,
   input  logic [AXI4_ID_W-1:0]                   m_axi4_rid,
   input  logic [AXI4_DATA_W-1:0]                 m_axi4_rdata,
   input  logic [1:0]                             m_axi4_rresp,
   input  logic                                   m_axi4_rlast,
   input  logic                                   m_axi4_rvalid,
   output logic                                   m_axi4_rready,
   output logic [$clog2(OUTSTD_DEPTH+1)-1:0]      outstd_cnt,
   output logic                                   error
);
   localparam int IDX_W = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
   localparam int PTR_W = $clog2(OUTSTD_DEPTH);
   localparam int CNT_W = $clog2(OUTSTD_DEPTH+1);

   logic [IDX_W-1:0]      r_rr_ptr;
   logic                  r_ar_vld;
   logic [AXI4_ADD_W-1:0] r_araddr;
   logic [7:0]            r_arlen;
   logic [2:0]            r_arsize;
   logic [1:0]            r_arburst;
   logic [IDX_W-1:0]      r_fifo_mem [OUTSTD_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_error;

   logic                  w_gnt_vld;
   logic [IDX_W-1:0]      w_gnt_idx;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic                  w_ar_take;
   logic                  w_r_accept;
   logic                  w_pop;
   logic [IDX_W-1:0]      w_head;
   logic                  w_unused;

   // Rotating priority: scan from highest offset down so the closest valid to r_rr_ptr wins.
   always_comb begin
      int j;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      j         = 0;
      for (int i = REQ_NB-1; i >= 0; i--) begin
         j = int'(r_rr_ptr) + i;
         if (j >= REQ_NB) j = j - REQ_NB;
         if (s_axi4_arvalid[IDX_W'(j)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = IDX_W'(j);
         end
      end
   end

   assign w_fifo_full  = (r_cnt == CNT_W'(OUTSTD_DEPTH));
   assign w_fifo_empty = (r_cnt == '0);
   // A same-cycle pop deliberately does not open a slot for this cycle's grant.
   assign w_ar_take    = w_gnt_vld & ~w_fifo_full & (~r_ar_vld | m_axi4_arready);

   always_comb begin
      s_axi4_arready = '0;
      if (w_ar_take) s_axi4_arready[w_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_ar_vld  <= 1'b0;
         r_rr_ptr  <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
      end else if (w_ar_take) begin
         r_ar_vld  <= 1'b1;
         r_araddr  <= s_axi4_araddr[w_gnt_idx];
         r_arlen   <= s_axi4_arlen[w_gnt_idx];
         r_arsize  <= s_axi4_arsize[w_gnt_idx];
         r_arburst <= s_axi4_arburst[w_gnt_idx];
         r_rr_ptr  <= (w_gnt_idx == IDX_W'(REQ_NB-1)) ? '0 : w_gnt_idx + IDX_W'(1);
      end else if (m_axi4_arready) begin
         r_ar_vld  <= 1'b0;
      end
   end

   // Single ID on the master keeps R beats in AR issue order, which the order FIFO relies on.
   assign m_axi4_arid    = '0;
   assign m_axi4_araddr  = r_araddr;
   assign m_axi4_arlen   = r_arlen;
   assign m_axi4_arsize  = r_arsize;
   assign m_axi4_arburst = r_arburst;
   assign m_axi4_arvalid = r_ar_vld;

   always_ff @(posedge clk) begin
      if (w_ar_take) r_fifo_mem[r_wr_ptr] <= w_gnt_idx;
   end

   assign w_head        = r_fifo_mem[r_rd_ptr];
   assign m_axi4_rready = ~w_fifo_empty & s_axi4_rready[w_head];
   assign w_r_accept    = m_axi4_rvalid & m_axi4_rready;
   assign w_pop         = w_r_accept & m_axi4_rlast;

   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_error  <= 1'b0;
      end else begin
         if (w_ar_take) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_ar_take, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
         if ((m_axi4_rvalid & w_fifo_empty) | (w_r_accept & (m_axi4_rresp != 2'b00)))
            r_error <= 1'b1;
      end
   end

   always_comb begin
      s_axi4_rvalid = '0;
      if (!w_fifo_empty) s_axi4_rvalid[w_head] = m_axi4_rvalid;
   end

   for (genvar gi = 0; gi < REQ_NB; gi++) begin : g_r_bcast
      assign s_axi4_rid[gi]   = '0;
      assign s_axi4_rdata[gi] = m_axi4_rdata;
      assign s_axi4_rresp[gi] = m_axi4_rresp;
      assign s_axi4_rlast[gi] = m_axi4_rlast;
   end

   assign outstd_cnt = r_cnt;
   assign error      = r_error;
   assign w_unused   = ^{s_axi4_arid, m_axi4_rid};
endmodule

// File: tb/tb_pep_ldg_axi_rd_arb.sv
// Directed bench for pep_ldg_axi_rd_arb: arbitration order, AR pass-through, FIFO full stall,
// R routing, head back-pressure and sticky error.
module tb_pep_ldg_axi_rd_arb;
   logic              clk = 1'b0;
   logic              s_rst;
   logic [1:0][3:0]   s_axi4_arid;
   logic [1:0][31:0]  s_axi4_araddr;
   logic [1:0][7:0]   s_axi4_arlen;
   logic [1:0][2:0]   s_axi4_arsize;
   logic [1:0][1:0]   s_axi4_arburst;
   logic [1:0]        s_axi4_arvalid;
   logic [1:0]        s_axi4_arready;
   logic [1:0][3:0]   s_axi4_rid;
   logic [1:0][63:0]  s_axi4_rdata;
   logic [1:0][1:0]   s_axi4_rresp;
   logic [1:0]        s_axi4_rlast;
   logic [1:0]        s_axi4_rvalid;
   logic [1:0]        s_axi4_rready;
   logic [3:0]        m_axi4_arid;
   logic [31:0]       m_axi4_araddr;
   logic [7:0]        m_axi4_arlen;
   logic [2:0]        m_axi4_arsize;
   logic [1:0]        m_axi4_arburst;
   logic              m_axi4_arvalid;
   logic              m_axi4_arready;
   logic [3:0]        m_axi4_rid;
   logic [63:0]       m_axi4_rdata;
   logic [1:0]        m_axi4_rresp;
   logic              m_axi4_rlast;
   logic              m_axi4_rvalid;
   logic              m_axi4_rready;
   logic [3:0]        outstd_cnt;
   logic              error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pep_ldg_axi_rd_arb #(
      .REQ_NB(2), .OUTSTD_DEPTH(8), .AXI4_ID_W(4), .AXI4_ADD_W(32), .AXI4_DATA_W(64)
   ) dut (
      .clk(clk), .s_rst(s_rst),
      .s_axi4_arid(s_axi4_arid), .s_axi4_araddr(s_axi4_araddr), .s_axi4_arlen(s_axi4_arlen),
      .s_axi4_arsize(s_axi4_arsize), .s_axi4_arburst(s_axi4_arburst),
      .s_axi4_arvalid(s_axi4_arvalid), .s_axi4_arready(s_axi4_arready),
      .s_axi4_rid(s_axi4_rid), .s_axi4_rdata(s_axi4_rdata), .s_axi4_rresp(s_axi4_rresp),
      .s_axi4_rlast(s_axi4_rlast), .s_axi4_rvalid(s_axi4_rvalid), .s_axi4_rready(s_axi4_rready),
      .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr), .m_axi4_arlen(m_axi4_arlen),
      .m_axi4_arsize(m_axi4_arsize), .m_axi4_arburst(m_axi4_arburst),
      .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
      .m_axi4_rid(m_axi4_rid), .m_axi4_rdata(m_axi4_rdata), .m_axi4_rresp(m_axi4_rresp),
      .m_axi4_rlast(m_axi4_rlast), .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready),
      .outstd_cnt(outstd_cnt), .error(error)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      s_rst          = 1'b1;
      s_axi4_arid    = '0;
      s_axi4_araddr  = '0;
      s_axi4_arlen   = '0;
      s_axi4_arsize  = '0;
      s_axi4_arburst = '0;
      s_axi4_arvalid = '0;
      s_axi4_rready  = '0;
      m_axi4_arready = 1'b0;
      m_axi4_rid     = '0;
      m_axi4_rdata   = '0;
      m_axi4_rresp   = '0;
      m_axi4_rlast   = 1'b0;
      m_axi4_rvalid  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      s_rst = 1'b0;
   endtask

   // Single-cycle AR request from one requester; expects an immediate grant.
   task automatic issue(input int req, input logic [7:0] len, input logic [31:0] addr);
      @(negedge clk);
      m_axi4_arready      = 1'b1;
      s_axi4_araddr[req]  = addr;
      s_axi4_arlen[req]   = len;
      s_axi4_arvalid      = 2'b01 << req;
      #1 check("issue_grant", s_axi4_arready, 2'b01 << req);
      @(posedge clk);
      #1 s_axi4_arvalid = '0;
   endtask

   int          own [6] = '{0, 0, 1, 0, 0, 0};
   logic        lst [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      s_rst = 1'b1;
      #1;
      check("rst_m_arvalid", m_axi4_arvalid, 0);
      check("rst_s_arready", s_axi4_arready, 0);
      check("rst_outstd",    outstd_cnt, 0);
      check("rst_error",     error, 0);
      check("rst_s_rvalid",  s_axi4_rvalid, 0);
      check("rst_m_rready",  m_axi4_rready, 0);
      do_reset();

      // Both requesters valid: grants alternate 0,1,0,1 at one AR per cycle
      s_axi4_araddr[0] = 32'h100;
      s_axi4_araddr[1] = 32'h200;
      s_axi4_arvalid   = 2'b11;
      m_axi4_arready   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr_grant", s_axi4_arready, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k > 0) begin
            check("rr_m_arvalid", m_axi4_arvalid, 1);
            check("rr_m_araddr",  m_axi4_araddr, (k % 2 == 1) ? 32'h100 : 32'h200);
         end
         @(posedge clk);
         @(negedge clk);
      end
      s_axi4_arvalid = '0;
      #1;
      check("rr_last_araddr", m_axi4_araddr, 32'h200);
      check("rr_outstd",      outstd_cnt, 4);

      // Req1 alone, arlen=3 @0x1000, held while arready=0
      do_reset();
      s_axi4_araddr[1]  = 32'h1000;
      s_axi4_arlen[1]   = 8'd3;
      s_axi4_arsize[1]  = 3'd3;
      s_axi4_arburst[1] = 2'd1;
      s_axi4_arid[1]    = 4'hF;
      s_axi4_arvalid    = 2'b10;
      #1 check("p_grant", s_axi4_arready, 2'b10);
      @(posedge clk);
      @(negedge clk);
      s_axi4_arvalid = '0;
      #1;
      check("p_arvalid", m_axi4_arvalid, 1);
      check("p_araddr",  m_axi4_araddr, 32'h1000);
      check("p_arlen",   m_axi4_arlen, 3);
      check("p_arsize",  m_axi4_arsize, 3);
      check("p_arburst", m_axi4_arburst, 1);
      check("p_arid",    m_axi4_arid, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("p_hold_arvalid", m_axi4_arvalid, 1);
      check("p_hold_araddr",  m_axi4_araddr, 32'h1000);
      m_axi4_arready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("p_drained", m_axi4_arvalid, 0);
      check("p_outstd",  outstd_cnt, 1);

      // Eight bursts outstanding stall the ninth; one rlast beat releases it the cycle after
      do_reset();
      m_axi4_arready = 1'b1;
      s_axi4_arvalid = 2'b01;
      for (int k = 0; k < 8; k++) begin
         #1 check("full_grant", s_axi4_arready, 2'b01);
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      check("full_stall",  s_axi4_arready, 2'b00);
      check("full_outstd", outstd_cnt, 8);
      m_axi4_rvalid = 1'b1;
      m_axi4_rlast  = 1'b1;
      s_axi4_rready = 2'b01;
      #1;
      check("full_m_rready",     m_axi4_rready, 1);
      check("full_s_rvalid",     s_axi4_rvalid, 2'b01);
      check("full_pop_no_grant", s_axi4_arready, 2'b00);
      @(posedge clk);
      @(negedge clk);
      m_axi4_rvalid = 1'b0;
      #1;
      check("full_after_pop", outstd_cnt, 7);
      check("full_regrant",   s_axi4_arready, 2'b01);
      @(posedge clk);
      @(negedge clk);
      s_axi4_arvalid = '0;
      #1 check("full_refill", outstd_cnt, 8);

      // Bursts 0(len1),1(len0),0(len2): beats 2/1/3 routed in order
      do_reset();
      issue(0, 8'd1, 32'h10);
      issue(1, 8'd0, 32'h20);
      issue(0, 8'd2, 32'h30);
      for (int b = 0; b < 6; b++) begin
         @(negedge clk);
         m_axi4_rvalid = 1'b1;
         m_axi4_rdata  = 64'hA0 + 64'(b);
         m_axi4_rlast  = lst[b];
         s_axi4_rready = 2'b11;
         #1;
         check("route_rvalid", s_axi4_rvalid, 2'b01 << own[b]);
         check("route_rready", m_axi4_rready, 1);
         check("route_rdata",  s_axi4_rdata[own[b]], 64'hA0 + 64'(b));
         check("route_rlast",  s_axi4_rlast[own[b]], lst[b]);
         @(posedge clk);
      end
      @(negedge clk);
      m_axi4_rvalid = 1'b0;
      #1 check("route_empty", outstd_cnt, 0);

      // Head owner not ready: nothing accepted, nothing leaks to req1
      do_reset();
      issue(0, 8'd0, 32'h40);
      issue(1, 8'd0, 32'h50);
      @(negedge clk);
      m_axi4_rvalid = 1'b1;
      m_axi4_rlast  = 1'b1;
      s_axi4_rready = 2'b10;
      #1;
      check("bp_m_rready", m_axi4_rready, 0);
      check("bp_s_rvalid", s_axi4_rvalid, 2'b01);
      @(posedge clk);
      @(negedge clk);
      #1 check("bp_outstd", outstd_cnt, 2);
      s_axi4_rready = 2'b11;
      #1 check("bp_release", m_axi4_rready, 1);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("bp_next_head", s_axi4_rvalid, 2'b10);
      check("bp_outstd2",   outstd_cnt, 1);
      m_axi4_rvalid = 1'b0;

      // Orphan beat sets sticky error; rresp=SLVERR does too, beat still forwarded
      do_reset();
      m_axi4_rvalid = 1'b1;
      m_axi4_rlast  = 1'b1;
      s_axi4_rready = 2'b11;
      #1;
      check("orph_m_rready", m_axi4_rready, 0);
      check("orph_err_pre",  error, 0);
      @(posedge clk);
      @(negedge clk);
      m_axi4_rvalid = 1'b0;
      #1 check("orph_err", error, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 check("orph_sticky", error, 1);
      do_reset();
      #1 check("err_cleared", error, 0);
      issue(0, 8'd0, 32'h60);
      @(negedge clk);
      m_axi4_rvalid = 1'b1;
      m_axi4_rlast  = 1'b1;
      m_axi4_rresp  = 2'b10;
      s_axi4_rready = 2'b01;
      #1;
      check("resp_fwd",     s_axi4_rresp[0], 2'b10);
      check("resp_rvalid",  s_axi4_rvalid, 2'b01);
      check("resp_err_pre", error, 0);
      @(posedge clk);
      @(negedge clk);
      m_axi4_rvalid = 1'b0;
      m_axi4_rresp  = 2'b00;
      #1 check("resp_err", error, 1);
      do_reset();
      #1 check("resp_err_rst", error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
